// File: rtl/mem_req_arbiter.sv
// Two-requester (instruction/data) arbiter onto one split-transaction memory port.
// Data wins when unlocked; an unaccepted grant is locked until accepted; responses route by FIFO.
module mem_req_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [1:0]  inst_size_i,
    input  logic [3:0]  inst_wstrb_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata_o,

    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [3:0]  data_wstrb_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_size_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_addr_ok_i,
    input  logic        mem_data_ok_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    localparam logic SrcInst = 1'b0;
    localparam logic SrcData = 1'b1;

    logic             lock_valid_q, lock_valid_d;
    logic             lock_src_q, lock_src_d;
    logic [DEPTH-1:0] src_fifo_q, src_fifo_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic full, empty;
    logic sel;
    logic push, pop;
    logic head_src;

    assign full     = (count_q == CntFull);
    assign empty    = (count_q == '0);
    assign sel      = lock_valid_q ? lock_src_q : data_req_i;
    assign head_src = src_fifo_q[rd_ptr_q];

    // full stalls the request even when a pop frees a slot this cycle
    assign mem_req_o = resetn & ~full & (lock_valid_q | data_req_i | inst_req_i);
    assign push      = mem_req_o & mem_addr_ok_i;
    assign pop       = resetn & mem_data_ok_i & ~empty;

    always_comb begin
        mem_wr_o    = inst_wr_i;
        mem_size_o  = inst_size_i;
        mem_wstrb_o = inst_wstrb_i;
        mem_addr_o  = inst_addr_i;
        mem_wdata_o = inst_wdata_i;
        if (sel == SrcData) begin
            mem_wr_o    = data_wr_i;
            mem_size_o  = data_size_i;
            mem_wstrb_o = data_wstrb_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign inst_addr_ok_o = push & (sel == SrcInst);
    assign data_addr_ok_o = push & (sel == SrcData);
    assign inst_data_ok_o = pop & (head_src == SrcInst);
    assign data_data_ok_o = pop & (head_src == SrcData);
    assign inst_rdata_o   = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_src_d   = lock_src_q;
        if (mem_req_o && !mem_addr_ok_i) begin
            lock_valid_d = 1'b1;
            lock_src_d   = sel;
        end else if (push) begin
            lock_valid_d = 1'b0;
        end
    end

    always_comb begin
        src_fifo_d = src_fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            src_fifo_d[wr_ptr_q] = sel;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid_q <= 1'b0;
            lock_src_q   <= 1'b0;
            src_fifo_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_src_q   <= lock_src_d;
            src_fifo_q   <= src_fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of outstanding requests.
module tb_mem_req_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = '0;
    logic [3:0]  inst_wstrb = '0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;

    int n_chk = 0;
    int n_pass = 0;

    mem_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req_i     (inst_req),
        .inst_wr_i      (inst_wr),
        .inst_size_i    (inst_size),
        .inst_wstrb_i   (inst_wstrb),
        .inst_addr_i    (inst_addr),
        .inst_wdata_i   (inst_wdata),
        .inst_addr_ok_o (inst_addr_ok),
        .inst_data_ok_o (inst_data_ok),
        .inst_rdata_o   (inst_rdata),
        .data_req_i     (data_req),
        .data_wr_i      (data_wr),
        .data_size_i    (data_size),
        .data_wstrb_i   (data_wstrb),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_addr_ok_o (data_addr_ok),
        .data_data_ok_o (data_data_ok),
        .data_rdata_o   (data_rdata),
        .mem_req_o      (mem_req),
        .mem_wr_o       (mem_wr),
        .mem_size_o     (mem_size),
        .mem_wstrb_o    (mem_wstrb),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_addr_ok_i  (mem_addr_ok),
        .mem_data_ok_i  (mem_data_ok),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: outstanding sources in accept order (0=inst, 1=data) and the held grant, if any.
    bit   mq[$];
    bit   m_lock = 1'b0;
    bit   m_owner = 1'b0;
    logic e_req = 1'b0, e_iaok = 1'b0, e_daok = 1'b0, e_idok = 1'b0, e_ddok = 1'b0;
    bit   e_sel = 1'b0;

    always @(negedge clk) begin
        bit grant_data;
        grant_data = m_lock ? m_owner : data_req;
        e_sel  = grant_data;
        e_req  = resetn && (mq.size() < DEPTH) && (m_lock || data_req || inst_req);
        e_iaok = e_req && mem_addr_ok && !grant_data;
        e_daok = e_req && mem_addr_ok && grant_data;
        e_idok = resetn && mem_data_ok && (mq.size() > 0) && (mq[0] == 1'b0);
        e_ddok = resetn && mem_data_ok && (mq.size() > 0) && (mq[0] == 1'b1);
        if (resetn && mem_data_ok && mq.size() == 0)
            $display("note: mem_data_ok with nothing outstanding at %0t", $time);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_iaok});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_daok});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_idok});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_ddok});
        if (e_req) begin
            chk("mem_addr", mem_addr, grant_data ? data_addr : inst_addr);
            chk("mem_wdata", mem_wdata, grant_data ? data_wdata : inst_wdata);
            chk("mem_ctl", {24'd0, mem_wr, mem_size, mem_wstrb},
                grant_data ? {24'd0, data_wr, data_size, data_wstrb}
                           : {24'd0, inst_wr, inst_size, inst_wstrb});
        end
        if (e_idok) chk("inst_rdata", inst_rdata, mem_rdata);
        if (e_ddok) chk("data_rdata", data_rdata, mem_rdata);
    end

    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            m_lock = 1'b0;
        end else begin
            if (e_idok || e_ddok) void'(mq.pop_front());
            if (e_iaok || e_daok) begin
                mq.push_back(e_sel);
                m_lock = 1'b0;
            end else if (e_req) begin
                m_lock  = 1'b1;
                m_owner = e_sel;
            end
        end
    end

    task automatic new_inst();
        inst_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom | 32'h1;
        data_wdata = $urandom;
    endtask

    // One cycle: drive after the edge, leave time for the literal checks before the negedge.
    task automatic cyc(input logic rn, input logic ir, input logic dr, input logic aok,
                       input logic dok, input bit ni = 1'b0, input bit nd = 1'b0);
        @(posedge clk);
        #1;
        if (ni) new_inst();
        if (nd) new_data();
        resetn      = rn;
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = $urandom;
        #3;
    endtask

    initial begin
        bit ip, dp;

        // Reset holds every control output low whatever the inputs.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

        // Simultaneous requests: data first, inst next cycle.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("prio addr", mem_addr, data_addr);
        chk("prio oks", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("prio inst next", {31'd0, inst_addr_ok}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ret data", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        chk("ret data rdata", data_rdata, mem_rdata);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ret inst", {30'd0, inst_data_ok, data_data_ok}, 32'd2);

        // Locked inst grant is not preempted by a later data request.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lock c2 addr", mem_addr, inst_addr);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lock c3 addr", mem_addr, inst_addr);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lock c4 addr", mem_addr, inst_addr);
        chk("lock c4 oks", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("lock c5 data", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Ordered return inst, data, inst.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("order 1", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        chk("order 1 rdata", inst_rdata, mem_rdata);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("order 2", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("order 3", {30'd0, inst_data_ok, data_data_ok}, 32'd2);

        // Full: no request even with a same-cycle pop; issues on the next cycle.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("full mem_req", {31'd0, mem_req}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("full pop mem_req", {31'd0, mem_req}, 32'd0);
        chk("full pop data_ok", {31'd0, inst_data_ok}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("after pop mem_req", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Push and pop in one cycle with two outstanding.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("pushpop oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
            32'h5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pushpop ret1", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pushpop ret2", {30'd0, inst_data_ok, data_data_ok}, 32'd1);

        // Reset mid-flight with three outstanding and a lock, then a stray return.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stray data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        chk("stray mem_req", {31'd0, mem_req}, 32'd0);

        // Random traffic; requesters hold until the model says they were accepted.
        ip = 1'b0;
        dp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (ip && e_iaok) ip = 1'b0;
            if (dp && e_daok) dp = 1'b0;
            if (!ip && $urandom_range(0, 1) == 0) begin
                ip = 1'b1;
                new_inst();
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1;
                new_data();
            end
            inst_req    = ip;
            data_req    = dp;
            resetn      = ($urandom_range(0, 399) != 0);
            mem_addr_ok = ($urandom_range(0, 4) < 3);
            mem_data_ok = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
